// File: rtl/mesi_isc_tb_pkg.sv
// Shared definitions for the MESI cache-state tracker: line state encodings,
// main-bus / coherence-bus command enums and the request FSM state type.
package mesi_isc_tb_pkg;

  // The coherence checker relies on these exact values.
  localparam logic [3:0] MesiM = 4'b1001;
  localparam logic [3:0] MesiE = 4'b0101;
  localparam logic [3:0] MesiS = 4'b0011;
  localparam logic [3:0] MesiI = 4'b0000;

  typedef enum logic [2:0] {
    MbusNop     = 3'd0,
    MbusRd      = 3'd1,
    MbusWr      = 3'd2,
    MbusWrBroad = 3'd3
  } mbus_cmd_e;

  typedef enum logic [2:0] {
    CbusNop     = 3'd0,
    CbusWrSnoop = 3'd1,
    CbusRdSnoop = 3'd2,
    CbusEnRd    = 3'd3,
    CbusEnWr    = 3'd4
  } cbus_cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusReq,
    StWaitEn,
    StDone
  } fsm_state_e;

  // State of a line after a snoop: WR_SNOOP invalidates, RD_SNOOP demotes M/E to S.
  function automatic logic [3:0] snoop_next(input logic [3:0] cur, input logic is_wr);
    if (is_wr) begin
      snoop_next = MesiI;
    end else if (cur == MesiM || cur == MesiE) begin
      snoop_next = MesiS;
    end else begin
      snoop_next = cur;
    end
  endfunction

endpackage

// File: rtl/mesi_isc_tb_line_table.sv
// Per-line MESI state array with snoop, fill and upgrade write ports; a snoop
// to a line always wins over a fill or upgrade landing on the same edge.
module mesi_isc_tb_line_table
  import mesi_isc_tb_pkg::*;
#(
  parameter int unsigned ENTRIES = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    snoop_en_i,
  input  logic                    snoop_wr_i,
  input  logic [3:0]              snoop_idx_i,
  input  logic                    fill_en_i,
  input  logic [3:0]              fill_idx_i,
  input  logic [3:0]              fill_state_i,
  input  logic                    upg_en_i,
  input  logic [3:0]              upg_idx_i,
  input  logic [3:0]              cpu_idx_i,
  output logic [3:0]              cpu_state_o,
  output logic [3:0]              snoop_state_o,
  output logic [ENTRIES-1:0][3:0] state_o
);

  logic [ENTRIES-1:0][3:0] state_q, state_d;

  // Out-of-range indices read back as I and are never written.
  function automatic logic [3:0] lookup(input logic [ENTRIES-1:0][3:0] arr,
                                        input logic [3:0]              idx);
    lookup = MesiI;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (idx == 4'(i)) begin
        lookup = arr[i];
      end
    end
  endfunction

  always_comb begin
    state_d = state_q;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (fill_en_i && fill_idx_i == 4'(i)) begin
        state_d[i] = fill_state_i;
      end
      if (upg_en_i && upg_idx_i == 4'(i)) begin
        state_d[i] = MesiM;
      end
      if (snoop_en_i && snoop_idx_i == 4'(i)) begin
        state_d[i] = snoop_next(state_q[i], snoop_wr_i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign cpu_state_o   = lookup(state_q, cpu_idx_i);
  assign snoop_state_o = lookup(state_q, snoop_idx_i);
  assign state_o       = state_q;

endmodule

// File: rtl/mesi_isc_tb_cache_state_tracker.sv
// Tracks the MESI state of one CPU's cache lines against main-bus and coherence-bus
// traffic. Define MESI_ISC_TB_TRACKER_STATS_EN to add invalidation/upgrade counters.
module mesi_isc_tb_cache_state_tracker
  import mesi_isc_tb_pkg::*;
#(
  parameter int unsigned CPU_ID  = 0,
  parameter int unsigned ENTRIES = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_rd_i,
  input  logic                    cpu_wr_i,
  input  logic [3:0]              cpu_idx_i,
  output logic                    cpu_ack_o,
  output logic [2:0]              mbus_cmd_o,
  input  logic                    mbus_ack_i,
  input  logic [2:0]              cbus_cmd_i,
  input  logic [3:0]              cbus_idx_i,
  input  logic                    cbus_excl_i,
  output logic                    cbus_ack_o,
`ifdef MESI_ISC_TB_TRACKER_STATS_EN
  output logic [15:0]             stat_inv_o,
  output logic [15:0]             stat_upg_o,
`endif
  output logic [ENTRIES-1:0][3:0] cache_state_o
);

  fsm_state_e fsm_q;
  mbus_cmd_e  mbus_cmd_q, miss_cmd;
  cbus_cmd_e  cbus_cmd;
  logic       cpu_ack_q, cbus_ack_q;
  logic [3:0] pend_idx_q;

  logic       cpu_req, cpu_idx_ok, cbus_idx_ok, cbus_new;
  logic       snoop_en, snoop_wr, snoop_hit_local, local_hit;
  logic       en_hit, upg_en;
  logic [3:0] cur_state, snoop_state, fill_state;

  assign cbus_cmd    = cbus_cmd_e'(cbus_cmd_i);
  assign cpu_req     = cpu_rd_i | cpu_wr_i;
  assign cpu_idx_ok  = 32'(cpu_idx_i) < ENTRIES;
  assign cbus_idx_ok = 32'(cbus_idx_i) < ENTRIES;

  // The ISC holds a command until acked, so only the first cycle of it counts.
  assign cbus_new = (cbus_cmd != CbusNop) && !cbus_ack_q;
  assign snoop_wr = (cbus_cmd == CbusWrSnoop);
  assign snoop_en = cbus_new && cbus_idx_ok && (snoop_wr || cbus_cmd == CbusRdSnoop);

  // A local request racing a snoop on its own line waits a cycle for the new state.
  assign snoop_hit_local = snoop_en && (cbus_idx_i == cpu_idx_i);

  always_comb begin
    local_hit = 1'b0;
    miss_cmd  = MbusNop;
    if (cpu_wr_i) begin
      local_hit = (cur_state == MesiM) || (cur_state == MesiE);
      miss_cmd  = (cur_state == MesiS) ? MbusWrBroad : MbusWr;
    end else begin
      local_hit = (cur_state != MesiI);
      miss_cmd  = MbusRd;
    end
  end

  assign upg_en = (fsm_q == StIdle) && cpu_req && cpu_wr_i && cpu_idx_ok &&
                  !snoop_hit_local && (cur_state == MesiE);

  assign en_hit = (fsm_q == StWaitEn) && cbus_new && (cbus_idx_i == pend_idx_q) &&
                  (cbus_cmd == CbusEnRd || cbus_cmd == CbusEnWr);

  assign fill_state = (cbus_cmd == CbusEnWr) ? MesiM : (cbus_excl_i ? MesiE : MesiS);

  mesi_isc_tb_line_table #(
    .ENTRIES (ENTRIES)
  ) u_line_table (
    .clk           (clk),
    .rst           (rst),
    .snoop_en_i    (snoop_en),
    .snoop_wr_i    (snoop_wr),
    .snoop_idx_i   (cbus_idx_i),
    .fill_en_i     (en_hit),
    .fill_idx_i    (pend_idx_q),
    .fill_state_i  (fill_state),
    .upg_en_i      (upg_en),
    .upg_idx_i     (cpu_idx_i),
    .cpu_idx_i     (cpu_idx_i),
    .cpu_state_o   (cur_state),
    .snoop_state_o (snoop_state),
    .state_o       (cache_state_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= StIdle;
      mbus_cmd_q <= MbusNop;
      cpu_ack_q  <= 1'b0;
      cbus_ack_q <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      cbus_ack_q <= cbus_new;
      cpu_ack_q  <= 1'b0;
      case (fsm_q)
        StIdle: begin
          if (cpu_req && !snoop_hit_local) begin
            if (!cpu_idx_ok || local_hit) begin
              fsm_q     <= StDone;
              cpu_ack_q <= 1'b1;
            end else begin
              mbus_cmd_q <= miss_cmd;
              pend_idx_q <= cpu_idx_i;
              fsm_q      <= StBusReq;
            end
          end
        end
        StBusReq: begin
          if (mbus_ack_i) begin
            mbus_cmd_q <= MbusNop;
            fsm_q      <= StWaitEn;
          end
        end
        StWaitEn: begin
          if (en_hit) begin
            fsm_q     <= StDone;
            cpu_ack_q <= 1'b1;
          end
        end
        StDone: begin
          fsm_q <= StIdle;
        end
        default: begin
          fsm_q <= StIdle;
        end
      endcase
    end
  end

  assign cpu_ack_o  = cpu_ack_q;
  assign cbus_ack_o = cbus_ack_q;
  assign mbus_cmd_o = mbus_cmd_q;

`ifdef MESI_ISC_TB_TRACKER_STATS_EN
  logic [15:0] stat_inv_q, stat_upg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_inv_q <= '0;
      stat_upg_q <= '0;
    end else begin
      if (snoop_en && snoop_wr && snoop_state != MesiI && stat_inv_q != 16'hFFFF) begin
        stat_inv_q <= stat_inv_q + 16'd1;
      end
      if (upg_en && stat_upg_q != 16'hFFFF) begin
        stat_upg_q <= stat_upg_q + 16'd1;
      end
    end
  end

  assign stat_inv_o = stat_inv_q;
  assign stat_upg_o = stat_upg_q;
`else
  // Only the stats counters look at the pre-snoop state of the snooped line.
  logic unused_snoop_state;
  assign unused_snoop_state = ^snoop_state;
`endif

endmodule

// File: tb/tb_mesi_isc_tb_cache_state_tracker.sv
// Directed self-checking bench for the cache-state tracker: drives the CPU, mbus and
// cbus sides on the falling edge and checks outputs there.
module tb_mesi_isc_tb_cache_state_tracker;

  localparam logic [3:0] SM = 4'b1001;
  localparam logic [3:0] SE = 4'b0101;
  localparam logic [3:0] SS = 4'b0011;
  localparam logic [3:0] SI = 4'b0000;

  localparam logic [2:0] M_NOP = 3'd0, M_RD = 3'd1, M_WR = 3'd2, M_WRB = 3'd3;
  localparam logic [2:0] C_NOP = 3'd0, C_WRS = 3'd1, C_RDS = 3'd2, C_ENRD = 3'd3,
                         C_ENWR = 3'd4;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_rd, cpu_wr, cpu_ack;
  logic [3:0]      cpu_idx;
  logic [2:0]      mbus_cmd;
  logic            mbus_ack;
  logic [2:0]      cbus_cmd;
  logic [3:0]      cbus_idx;
  logic            cbus_excl, cbus_ack;
  logic [9:0][3:0] cache_state;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mesi_isc_tb_cache_state_tracker #(
    .CPU_ID  (0),
    .ENTRIES (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_rd_i      (cpu_rd),
    .cpu_wr_i      (cpu_wr),
    .cpu_idx_i     (cpu_idx),
    .cpu_ack_o     (cpu_ack),
    .mbus_cmd_o    (mbus_cmd),
    .mbus_ack_i    (mbus_ack),
    .cbus_cmd_i    (cbus_cmd),
    .cbus_idx_i    (cbus_idx),
    .cbus_excl_i   (cbus_excl),
    .cbus_ack_o    (cbus_ack),
    .cache_state_o (cache_state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cbus_send(input string tag, input logic [2:0] cmd, input logic [3:0] idx);
    cbus_cmd = cmd;
    cbus_idx = idx;
    @(negedge clk);
    chk({tag, "_cbus_ack"}, 64'(cbus_ack), 64'd1);
    @(negedge clk);
    chk({tag, "_cbus_ack_once"}, 64'(cbus_ack), 64'd0);
    cbus_cmd = C_NOP;
  endtask

  task automatic mbus_accept(input string tag);
    mbus_ack = 1'b1;
    @(negedge clk);
    mbus_ack = 1'b0;
    chk({tag, "_mbus_nop"}, 64'(mbus_cmd), 64'(M_NOP));
  endtask

  task automatic en_fill(input string tag, input logic [2:0] cmd, input int idx,
                         input logic excl, input logic [3:0] exp_state);
    cbus_cmd  = cmd;
    cbus_idx  = 4'(idx);
    cbus_excl = excl;
    @(negedge clk);
    chk({tag, "_cpu_ack"}, 64'(cpu_ack), 64'd1);
    chk({tag, "_en_ack"}, 64'(cbus_ack), 64'd1);
    chk({tag, "_state"}, 64'(cache_state[idx]), 64'(exp_state));
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    @(negedge clk);
    chk({tag, "_cpu_ack_pulse"}, 64'(cpu_ack), 64'd0);
    chk({tag, "_en_ack_pulse"}, 64'(cbus_ack), 64'd0);
    cbus_cmd  = C_NOP;
    cbus_excl = 1'b0;
  endtask

  task automatic cpu_miss(input string tag, input logic wr, input int idx,
                          input logic [2:0] exp_cmd, input logic [2:0] en_cmd,
                          input logic excl, input logic [3:0] exp_state);
    cpu_rd  = ~wr;
    cpu_wr  = wr;
    cpu_idx = 4'(idx);
    @(negedge clk);
    chk({tag, "_cmd"}, 64'(mbus_cmd), 64'(exp_cmd));
    mbus_accept(tag);
    en_fill(tag, en_cmd, idx, excl, exp_state);
  endtask

  task automatic cpu_hit(input string tag, input logic wr, input int idx);
    cpu_rd  = ~wr;
    cpu_wr  = wr;
    cpu_idx = 4'(idx);
    @(negedge clk);
    chk({tag, "_ack"}, 64'(cpu_ack), 64'd1);
    chk({tag, "_no_bus"}, 64'(mbus_cmd), 64'(M_NOP));
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_pulse"}, 64'(cpu_ack), 64'd0);
  endtask

  initial begin
    logic [39:0] snap;
    logic        seen;
    rst       = 1'b1;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_idx   = '0;
    mbus_ack  = 1'b0;
    cbus_cmd  = C_NOP;
    cbus_idx  = '0;
    cbus_excl = 1'b0;

    // Reset takes effect before any clock edge.
    #1;
    chk("rst_cache", 64'(cache_state), 64'd0);
    chk("rst_mbus", 64'(mbus_cmd), 64'(M_NOP));
    chk("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    chk("rst_cbus_ack", 64'(cbus_ack), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Read miss on line 3, command held until accepted, exclusive fill.
    cpu_rd  = 1'b1;
    cpu_idx = 4'd3;
    @(negedge clk);
    chk("rd3_cmd", 64'(mbus_cmd), 64'(M_RD));
    @(negedge clk);
    chk("rd3_cmd_held", 64'(mbus_cmd), 64'(M_RD));
    mbus_accept("rd3");
    chk("rd3_pending_state", 64'(cache_state[3]), 64'(SI));
    en_fill("rd3", C_ENRD, 3, 1'b1, SE);

    // Silent E->M upgrade.
    cpu_hit("wr3_upg", 1'b1, 3);
    chk("wr3_state", 64'(cache_state[3]), 64'(SM));

    // Shared line 5, then write upgrade through WR_BROAD.
    cpu_miss("rd5", 1'b0, 5, M_RD, C_ENRD, 1'b0, SS);
    cpu_miss("wr5", 1'b1, 5, M_WRB, C_ENWR, 1'b0, SM);

    // Line 2 to M, then snooped down to S and to I.
    cpu_miss("wr2", 1'b1, 2, M_WR, C_ENWR, 1'b0, SM);
    cbus_send("rds2", C_RDS, 4'd2);
    chk("rds2_state", 64'(cache_state[2]), 64'(SS));
    cbus_send("wrs2", C_WRS, 4'd2);
    chk("wrs2_state", 64'(cache_state[2]), 64'(SI));

    // Line 7 E; WR_SNOOP races a local write to the same line.
    cpu_miss("rd7", 1'b0, 7, M_RD, C_ENRD, 1'b1, SE);
    cpu_wr   = 1'b1;
    cpu_idx  = 4'd7;
    cbus_cmd = C_WRS;
    cbus_idx = 4'd7;
    @(negedge clk);
    chk("race7_state", 64'(cache_state[7]), 64'(SI));
    chk("race7_no_ack", 64'(cpu_ack), 64'd0);
    chk("race7_cbus_ack", 64'(cbus_ack), 64'd1);
    chk("race7_stall", 64'(mbus_cmd), 64'(M_NOP));
    @(negedge clk);
    chk("race7_cmd", 64'(mbus_cmd), 64'(M_WR));
    chk("race7_cbus_ack_once", 64'(cbus_ack), 64'd0);
    cbus_cmd = C_NOP;
    mbus_accept("race7");
    en_fill("race7", C_ENWR, 7, 1'b0, SM);

    // Read hit on M line: no bus traffic.
    cpu_hit("rd7_hit", 1'b0, 7);
    chk("rd7_hit_state", 64'(cache_state[7]), 64'(SM));

    // Snoop on a pending line, then the fill overrides it.
    cpu_rd  = 1'b1;
    cpu_idx = 4'd4;
    @(negedge clk);
    chk("rd4_cmd", 64'(mbus_cmd), 64'(M_RD));
    mbus_accept("rd4");
    cbus_send("wrs4", C_WRS, 4'd4);
    chk("wrs4_state", 64'(cache_state[4]), 64'(SI));
    en_fill("rd4", C_ENRD, 4, 1'b1, SE);

    // Last valid index and out-of-range indices.
    cpu_miss("rd9", 1'b0, 9, M_RD, C_ENRD, 1'b0, SS);
    snap = cache_state;
    cpu_hit("rd12_oor", 1'b0, 12);
    cpu_hit("wr15_oor", 1'b1, 15);
    cbus_send("wrs12_oor", C_WRS, 4'd12);
    chk("oor_no_change", 64'(cache_state), 64'(snap));

    // Reset during BUS_REQ.
    cpu_rd  = 1'b1;
    cpu_idx = 4'd1;
    @(negedge clk);
    chk("rd1_cmd", 64'(mbus_cmd), 64'(M_RD));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_mbus", 64'(mbus_cmd), 64'(M_NOP));
    chk("rst_mid_cache", 64'(cache_state), 64'd0);
    @(negedge clk);
    cpu_rd = 1'b0;
    rst    = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | cpu_ack;
    end
    chk("rst_mid_no_ack", 64'(seen), 64'd0);
    chk("rst_mid_idle_mbus", 64'(mbus_cmd), 64'(M_NOP));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mesi_isc_tb_cache_state_tracker.md
MESI_ISC_TB_CACHE_STATE_TRACKER -- requirements
Module: mesi_isc_tb_cache_state_tracker

Interface
REQ-001 Parameter CPU_ID, default 0, CPU number (0..3) of this tracker.
REQ-002 Parameter ENTRIES, default 10, number of tracked cache lines.
REQ-003 clk  input  1  single clock, all state sampled on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cpu_rd_i  input  1  local read request, held until cpu_ack_o.
REQ-006 cpu_wr_i  input  1  local write request, held until cpu_ack_o.
REQ-007 cpu_idx_i  input  4  line index of local request.
REQ-008 cpu_ack_o  output  1  one-cycle completion pulse for local request.
REQ-009 mbus_cmd_o  output  3  main-bus command to ISC: NOP, RD, WR, WR_BROAD.
REQ-010 mbus_ack_i  input  1  ISC accepted mbus_cmd_o.
REQ-011 cbus_cmd_i  input  3  coherence command from ISC: NOP, WR_SNOOP, RD_SNOOP, EN_RD, EN_WR.
REQ-012 cbus_idx_i  input  4  line index of cbus_cmd_i.
REQ-013 cbus_excl_i  input  1  with EN_RD: no other sharer exists.
REQ-014 cbus_ack_o  output  1  one-cycle acknowledge of a non-NOP cbus_cmd_i.
REQ-015 cache_state_o  output  ENTRIES x 4  per-line MESI state, consumed by the coherence assertion checker.

Function
REQ-016 FSM states IDLE, BUS_REQ, WAIT_EN, DONE.
REQ-017 IDLE, read, state != I: -> DONE, no bus traffic.
REQ-018 IDLE, write, state M: -> DONE; state E: line set M same edge, -> DONE.
REQ-019 IDLE, read miss (I): mbus_cmd_o=RD, -> BUS_REQ; write to I: WR; write to S: WR_BROAD.
REQ-020 BUS_REQ: mbus_cmd_o held stable until mbus_ack_i=1, then NOP next cycle, -> WAIT_EN.
REQ-021 WAIT_EN: EN_RD for own index -> line E if cbus_excl_i else S; EN_WR -> line M; -> DONE.
REQ-022 DONE: cpu_ack_o=1 exactly one cycle, -> IDLE; no back-to-back acks without an IDLE cycle.
REQ-023 Both cpu_rd_i and cpu_wr_i high: treated as write.
REQ-024 WR_SNOOP idx: line -> I; RD_SNOOP idx: M/E -> S, S/I unchanged.
REQ-025 cbus_ack_o asserted the cycle after a non-NOP cbus_cmd_i is first seen; ISC holds command until ack; one ack per command.
REQ-026 Snoop and local hit on same index same cycle: snoop applied, local request re-evaluated next cycle from updated state.
REQ-027 Snoop to index pending in WAIT_EN: snoop applied; subsequent EN_RD/EN_WR overrides it.
REQ-028 Index >= ENTRIES: local request acked via DONE, snoop acked, no state change, no bus command.
REQ-029 State encoding: M=4'b1001, E=4'b0101, S=4'b0011, I=4'b0000; no other value ever on cache_state_o.

Reset
REQ-030 rst high: all lines I, FSM IDLE, mbus_cmd_o=NOP, cpu_ack_o=0, cbus_ack_o=0, immediately, without clock.
REQ-031 Reset mid-transaction abandons pending bus command; no ack issued for it after release.

Configuration
REQ-032 Macro MESI_ISC_TB_TRACKER_STATS_EN defined: adds outputs stat_inv_o (16 bit, count of lines forced to I by WR_SNOOP from non-I) and stat_upg_o (16 bit, count of E->M silent upgrades), saturating at 16'hFFFF, reset 0.
REQ-033 Macro undefined: neither output nor counter exists; all other behaviour identical.

Structure
REQ-034 Shared package mesi_isc_tb_pkg holds MESI state encodings, mbus/cbus command enums, FSM state typedef.
REQ-035 One sub-module mesi_isc_tb_line_table: ENTRIES x 4 state array with snoop/fill/upgrade write ports and snoop-priority ordering.

Verification
REQ-036 Reset, read idx 3 -> mbus_cmd_o=RD until ack; EN_RD, excl=1 -> cache_state_o[3]=E, one cpu_ack_o.
REQ-037 Line 3 E, write idx 3 -> no bus command, state M, cpu_ack_o within 2 cycles.
REQ-038 Line 5 S, write idx 5 -> WR_BROAD; EN_WR -> state M.
REQ-039 Line 2 M, RD_SNOOP idx 2 -> state S, cbus_ack_o single pulse next cycle; WR_SNOOP idx 2 -> I.
REQ-040 Line 7 E, WR_SNOOP idx 7 same cycle as write idx 7 -> line I, then WR issued, EN_WR -> M.
REQ-041 Assert rst during BUS_REQ -> all lines I, mbus_cmd_o=NOP immediately, no cpu_ack_o after release.
